inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
- REQ-001 SHALL: clk, input, 1, single clock; all state updates on the rising edge.
- REQ-002 SHALL: reset, input, 1, asynchronous, active-high reset.
- REQ-003 SHALL: parameter ADDR_W, default 8, instruction-memory address width.
- REQ-004 SHALL: encode, input, 1, request to encode and store one instruction.
- REQ-005 SHALL: fmt, input, 1, 0 = register form, 1 = shift form.
- REQ-006 SHALL: cond, input, 2, condition field.
- REQ-007 SHALL: op_code, input, 4, opcode field.
- REQ-008 SHALL: dest_reg, src_reg1, src_reg2, input, 3 each, register fields.
- REQ-009 SHALL: shift_bits, input, 4, shift amount (shift form only).
- REQ-010 SHALL: load_addr, input, 1, load start_addr into the write pointer.
- REQ-011 SHALL: start_addr, input, ADDR_W, new write-pointer value.
- REQ-012 SHALL: ready, output, 1, high when an encode request can be accepted.
- REQ-013 SHALL: mem_we, output, 1, instruction-memory write request.
- REQ-014 SHALL: mem_addr, output, ADDR_W, write address.
- REQ-015 SHALL: mem_data, output, 16, encoded instruction word.
- REQ-016 SHALL: mem_ack, input, 1, memory accepted the write.
- REQ-017 SHALL: full, output, 1, pointer exhausted; no further writes until reload.
- REQ-018 SHALL: instr_count, output, ADDR_W+1, number of words written since the last reset or load.

Function
- REQ-019 SHALL: encoding, common fields: mem_data[15:14]=cond, [13:10]=op_code, [9:7]=dest_reg, [6:4]=src_reg1.
- REQ-020 SHALL: encoding, register form: [3:1]=src_reg2, [0]=0.
- REQ-021 SHALL: encoding, shift form: [3:0]=shift_bits.
- REQ-022 SHALL: FSM states are IDLE, WRITE and FULL; ready = (state==IDLE).
- REQ-023 SHALL: IDLE, encode=1, load_addr=0: register the encoded word and go to WRITE; mem_we=1 with valid mem_data and mem_addr on the next cycle (latency 1).
- REQ-024 SHALL: WRITE, mem_we, mem_data and mem_addr held stable until the first cycle with mem_ack=1; encode is ignored while in WRITE.
- REQ-025 SHALL: WRITE, on the mem_ack cycle: instr_count+1 and mem_we=0 next cycle.
- REQ-026 SHALL: WRITE, on the mem_ack cycle, if mem_addr != 2^ADDR_W-1: mem_addr+1 and go to IDLE.
- REQ-027 SHALL: WRITE, on the mem_ack cycle, if mem_addr == 2^ADDR_W-1: mem_addr unchanged (no wrap-around), full=1 and go to FULL.
- REQ-028 SHALL: FULL, encode is ignored and ready=0; only load_addr leaves FULL.
- REQ-029 SHALL: load_addr is honoured in IDLE or FULL only: mem_addr=start_addr, instr_count=0, full=0, next state IDLE; it is ignored in WRITE.
- REQ-030 SHALL: load_addr and encode both high in IDLE: load has priority and the encode is not accepted.
- REQ-031 SHALL: mem_ack is ignored outside WRITE.

Reset
- REQ-032 SHALL: on reset=1, immediately and independently of clk: state=IDLE, mem_we=0, mem_addr=0, mem_data=0, instr_count=0, full=0; ready=1 once reset is released.
- REQ-033 SHALL: reset during WRITE abandons the pending write (mem_we=0 at once), and the dropped word is not counted.

Verification
- REQ-034 SHALL: after reset, encode with fmt=0, cond=10, op=0011, dest=101, src1=010, src2=110 -> next cycle mem_we=1, mem_addr=0x00, mem_data=0x8EAC.
- REQ-035 SHALL: encode with fmt=1, cond=01, op=1001, dest=011, src1=111, shift=1010 -> mem_data=0x65FA.
- REQ-036 SHALL: hold mem_ack low 3 cycles, then pulse it -> mem_we and mem_data stable for 4 cycles, then mem_addr=1, instr_count=1, ready=1.
- REQ-037 SHALL: load_addr with start_addr=0xFF, then one encode acked -> full=1, mem_addr=0xFF, instr_count=1, and a further encode produces no mem_we.
- REQ-038 SHALL: load_addr with encode in IDLE -> no write issued, mem_addr=start_addr; load_addr pulsed during WRITE -> ignored.
- REQ-039 SHALL: reset asserted mid-WRITE with no clk edge -> mem_we=0 and instr_count=0 immediately.

Source files
------------

// File: rtl/inst_encoder.sv
// Instruction encoder: packs register/shift-form fields into a 16-bit word and
// writes it to instruction memory at an auto-incrementing pointer.
module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              encode,
  input  logic              fmt,
  input  logic [1:0]        cond,
  input  logic [3:0]        op_code,
  input  logic [2:0]        dest_reg,
  input  logic [2:0]        src_reg1,
  input  logic [2:0]        src_reg2,
  input  logic [3:0]        shift_bits,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              full,
  output logic [ADDR_W:0]   instr_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic        accept;
  logic        do_load;
  logic        ack;
  logic        last_addr;
  logic [15:0] enc_word;

  // Memory write handshake: mem_we is the valid, mem_ack the ready. The word
  // and address stay frozen while mem_we=1 and the transfer completes on the
  // first cycle both are high.
  assign accept    = (state == IDLE) && encode && !load_addr;
  assign do_load   = load_addr && (state != WRITE);
  assign ack       = (state == WRITE) && mem_ack;
  assign last_addr = (mem_addr == {ADDR_W{1'b1}});

  assign enc_word = {cond, op_code, dest_reg, src_reg1,
                     fmt ? shift_bits : {src_reg2, 1'b0}};

  assign ready     = (state == IDLE);
  assign mem_we    = (state == WRITE);
  assign full      = (state == FULL);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load_addr)   state_next = IDLE;
        else if (encode) state_next = WRITE;
      end
      WRITE: begin
        if (mem_ack) state_next = last_addr ? FULL : IDLE;
      end
      FULL: begin
        if (load_addr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pointer saturates at the top address; FULL then blocks further writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr    <= '0;
      mem_data    <= '0;
      instr_count <= '0;
    end else begin
      if (do_load) begin
        mem_addr    <= start_addr;
        instr_count <= '0;
      end
      if (accept) begin
        mem_data <= enc_word;
      end
      if (ack) begin
        instr_count <= instr_count + (ADDR_W+1)'(1);
        if (!last_addr) mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encoding forms, ack stalls, pointer load,
// saturation at the top address and asynchronous reset during a write.
module tb_inst_encoder;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              encode;
  logic              fmt;
  logic [1:0]        cond;
  logic [3:0]        op_code;
  logic [2:0]        dest_reg;
  logic [2:0]        src_reg1;
  logic [2:0]        src_reg2;
  logic [3:0]        shift_bits;
  logic              load_addr;
  logic [ADDR_W-1:0] start_addr;
  logic              ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              mem_ack;
  logic              full;
  logic [ADDR_W:0]   instr_count;
  logic [1:0]        dbg_state;

  int total;
  int bad;

  inst_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .encode(encode), .fmt(fmt), .cond(cond),
    .op_code(op_code), .dest_reg(dest_reg), .src_reg1(src_reg1),
    .src_reg2(src_reg2), .shift_bits(shift_bits), .load_addr(load_addr),
    .start_addr(start_addr), .ready(ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .full(full), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change on the falling edge, outputs are sampled on
  // the following falling edge after the rising edge in between.
  task automatic drive_encode(input logic f, input logic [1:0] c,
                              input logic [3:0] op, input logic [2:0] d,
                              input logic [2:0] s1, input logic [2:0] s2,
                              input logic [3:0] sh);
    encode = 1'b1; fmt = f; cond = c; op_code = op;
    dest_reg = d; src_reg1 = s1; src_reg2 = s2; shift_bits = sh;
    @(negedge clk);
    encode = 1'b0;
  endtask

  task automatic drive_ack();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic drive_load(input logic [ADDR_W-1:0] a);
    load_addr = 1'b1; start_addr = a;
    @(negedge clk);
    load_addr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0) begin $display("FAIL reset_we got=%b exp=0", mem_we); bad++; end
    total++; if (mem_addr !== 8'h00) begin $display("FAIL reset_addr got=%h exp=00", mem_addr); bad++; end
    total++; if (mem_data !== 16'h0000) begin $display("FAIL reset_data got=%h exp=0000", mem_data); bad++; end
    total++; if (instr_count !== 9'd0) begin $display("FAIL reset_count got=%0d exp=0", instr_count); bad++; end
    total++; if (full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", full); bad++; end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin $display("FAIL reset_ready got=%b exp=1", ready); bad++; end
  endtask

  task automatic test_reg_form_stall();
    drive_encode(1'b0, 2'b10, 4'b0011, 3'b101, 3'b010, 3'b110, 4'b0000);
    total++; if (mem_we !== 1'b1) begin $display("FAIL reg_we got=%b exp=1", mem_we); bad++; end
    total++; if (mem_addr !== 8'h00) begin $display("FAIL reg_addr got=%h exp=00", mem_addr); bad++; end
    total++; if (mem_data !== 16'h8EAC) begin $display("FAIL reg_data got=%h exp=8EAC", mem_data); bad++; end
    total++; if (ready !== 1'b0) begin $display("FAIL reg_ready got=%b exp=0", ready); bad++; end
    // Hold ack low for 3 cycles while offering a different encode.
    encode = 1'b1; fmt = 1'b1; cond = 2'b11; op_code = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (mem_we !== 1'b1 || mem_data !== 16'h8EAC || mem_addr !== 8'h00) begin
        $display("FAIL stall_hold cyc=%0d got we=%b data=%h addr=%h exp we=1 data=8EAC addr=00",
                 i, mem_we, mem_data, mem_addr);
        bad++;
      end
    end
    encode = 1'b0;
    drive_ack();
    total++; if (mem_we !== 1'b0) begin $display("FAIL ack_we got=%b exp=0", mem_we); bad++; end
    total++; if (mem_addr !== 8'h01) begin $display("FAIL ack_addr got=%h exp=01", mem_addr); bad++; end
    total++; if (instr_count !== 9'd1) begin $display("FAIL ack_count got=%0d exp=1", instr_count); bad++; end
    total++; if (ready !== 1'b1) begin $display("FAIL ack_ready got=%b exp=1", ready); bad++; end
  endtask

  task automatic test_shift_form();
    drive_encode(1'b1, 2'b01, 4'b1001, 3'b011, 3'b111, 3'b000, 4'b1010);
    total++; if (mem_data !== 16'h65FA) begin $display("FAIL shift_data got=%h exp=65FA", mem_data); bad++; end
    total++; if (mem_addr !== 8'h01) begin $display("FAIL shift_addr got=%h exp=01", mem_addr); bad++; end
    drive_ack();
    total++; if (mem_addr !== 8'h02 || instr_count !== 9'd2) begin
      $display("FAIL shift_ack got addr=%h cnt=%0d exp addr=02 cnt=2", mem_addr, instr_count); bad++;
    end
  endtask

  task automatic test_load_priority();
    encode = 1'b1; fmt = 1'b0;
    drive_load(8'h40);
    encode = 1'b0;
    total++; if (mem_we !== 1'b0) begin $display("FAIL loadpri_we got=%b exp=0", mem_we); bad++; end
    total++; if (mem_addr !== 8'h40 || instr_count !== 9'd0) begin
      $display("FAIL loadpri_addr got addr=%h cnt=%0d exp addr=40 cnt=0", mem_addr, instr_count); bad++;
    end
    // Ack outside WRITE must not move anything.
    drive_ack();
    total++; if (mem_addr !== 8'h40 || instr_count !== 9'd0) begin
      $display("FAIL idle_ack got addr=%h cnt=%0d exp addr=40 cnt=0", mem_addr, instr_count); bad++;
    end
    drive_encode(1'b0, 2'b00, 4'b0001, 3'b001, 3'b001, 3'b001, 4'b0000);
    drive_load(8'h10);
    total++; if (mem_we !== 1'b1 || mem_addr !== 8'h40 || mem_data !== 16'h0492) begin
      $display("FAIL write_load got we=%b addr=%h data=%h exp we=1 addr=40 data=0492",
               mem_we, mem_addr, mem_data); bad++;
    end
    drive_ack();
    total++; if (mem_addr !== 8'h41 || instr_count !== 9'd1) begin
      $display("FAIL write_load_ack got addr=%h cnt=%0d exp addr=41 cnt=1", mem_addr, instr_count); bad++;
    end
  endtask

  task automatic test_full();
    drive_load(8'hFF);
    drive_encode(1'b1, 2'b11, 4'b0101, 3'b111, 3'b000, 3'b000, 4'b1111);
    total++; if (mem_addr !== 8'hFF || mem_data !== 16'hD78F) begin
      $display("FAIL top_write got addr=%h data=%h exp addr=FF data=D78F", mem_addr, mem_data); bad++;
    end
    drive_ack();
    total++; if (full !== 1'b1 || ready !== 1'b0) begin
      $display("FAIL full_flag got full=%b ready=%b exp full=1 ready=0", full, ready); bad++;
    end
    total++; if (mem_addr !== 8'hFF || instr_count !== 9'd1 || mem_we !== 1'b0) begin
      $display("FAIL full_state got addr=%h cnt=%0d we=%b exp addr=FF cnt=1 we=0",
               mem_addr, instr_count, mem_we); bad++;
    end
    drive_encode(1'b0, 2'b01, 4'b0001, 3'b001, 3'b001, 3'b001, 4'b0000);
    total++; if (mem_we !== 1'b0 || full !== 1'b1) begin
      $display("FAIL full_encode got we=%b full=%b exp we=0 full=1", mem_we, full); bad++;
    end
    drive_ack();
    total++; if (instr_count !== 9'd1 || mem_addr !== 8'hFF) begin
      $display("FAIL full_ack got addr=%h cnt=%0d exp addr=FF cnt=1", mem_addr, instr_count); bad++;
    end
    drive_load(8'h05);
    total++; if (full !== 1'b0 || ready !== 1'b1 || mem_addr !== 8'h05 || instr_count !== 9'd0) begin
      $display("FAIL full_reload got full=%b ready=%b addr=%h cnt=%0d exp full=0 ready=1 addr=05 cnt=0",
               full, ready, mem_addr, instr_count); bad++;
    end
  endtask

  task automatic test_reset_mid_write();
    drive_encode(1'b0, 2'b10, 4'b0011, 3'b101, 3'b010, 3'b110, 4'b0000);
    drive_ack();
    drive_encode(1'b1, 2'b01, 4'b1001, 3'b011, 3'b111, 3'b000, 4'b1010);
    total++; if (mem_we !== 1'b1 || instr_count !== 9'd1) begin
      $display("FAIL pre_reset got we=%b cnt=%0d exp we=1 cnt=1", mem_we, instr_count); bad++;
    end
    #2;
    reset = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0 || instr_count !== 9'd0 || mem_addr !== 8'h00 || mem_data !== 16'h0000) begin
      $display("FAIL async_reset got we=%b cnt=%0d addr=%h data=%h exp we=0 cnt=0 addr=00 data=0000",
               mem_we, instr_count, mem_addr, mem_data); bad++;
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || mem_we !== 1'b0 || instr_count !== 9'd0) begin
      $display("FAIL post_reset got ready=%b we=%b cnt=%0d exp ready=1 we=0 cnt=0",
               ready, mem_we, instr_count); bad++;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    encode = 1'b0; fmt = 1'b0; cond = '0; op_code = '0; dest_reg = '0;
    src_reg1 = '0; src_reg2 = '0; shift_bits = '0; load_addr = 1'b0;
    start_addr = '0; mem_ack = 1'b0; reset = 1'b0;
    #2;
    test_reset();
    test_reg_form_stall();
    test_shift_form();
    test_load_priority();
    test_full();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is short, so any overrun means a hang.
  initial begin
    #20000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
